// File: rtl/fma_rr_scheduler.sv
// Round-robin front end that shares one fixed-latency pipelined FMA among NREQ requesters.
// An issue-tag shift register follows each operation so the result returns to its owner.
module fma_rr_scheduler #(
  parameter int NREQ = 2,
  parameter int LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [32*NREQ-1:0]   req_c,
  output logic [31:0]          fma_a,
  output logic [31:0]          fma_b,
  output logic [31:0]          fma_c,
  input  logic [31:0]          fma_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_result,
  output logic                 busy,
  output logic [15:0]          issue_cnt
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]          last_q, last_d;
  logic [31:0]             fma_a_q, fma_a_d, fma_b_q, fma_b_d, fma_c_q, fma_c_d;
  logic [LAT:0]            tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_result_q, rsp_result_d;
  logic [15:0]             issue_cnt_q, issue_cnt_d;

  logic [NREQ-1:0]         ready_s;
  logic [IDW-1:0]          gnt_id_s;
  logic                    found_s;
  logic                    hs_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [IDW:0] idx_v;
    found_s  = 1'b0;
    gnt_id_s = last_q;
    ready_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_v = {1'b0, last_q} + (IDW+1)'(k);
      if (idx_v >= (IDW+1)'(NREQ)) begin
        idx_v = idx_v - (IDW+1)'(NREQ);
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && req_valid[idx_v[IDW-1:0]]) begin
        found_s  = 1'b1;
        gnt_id_s = idx_v[IDW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
    // Grants are suppressed during reset so nothing looks accepted while state is cleared.
    if (found_s && !rst) begin
      ready_s[gnt_id_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign hs_s = |ready_s;

  // Next-state for operands, issue tags, response and counters.
  always_comb begin
    last_d       = last_q;
    fma_a_d      = fma_a_q;
    fma_b_d      = fma_b_q;
    fma_c_d      = fma_c_q;
    issue_cnt_d  = issue_cnt_q;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    tag_vld_d    = {tag_vld_q[LAT-1:0], hs_s};
    tag_id_d[0]  = gnt_id_s;
    for (int k = 1; k <= LAT; k++) begin
      tag_id_d[k] = tag_id_q[k-1];
    end
    if (hs_s) begin
      last_d      = gnt_id_s;
      fma_a_d     = req_a[{gnt_id_s, 5'd0} +: 32];
      fma_b_d     = req_b[{gnt_id_s, 5'd0} +: 32];
      fma_c_d     = req_c[{gnt_id_s, 5'd0} +: 32];
      issue_cnt_d = issue_cnt_q + 16'd1;
    end else begin
      last_d      = last_q;
    end
    // The final tag stage lines up with the FMA output for that operation.
    if (tag_vld_q[LAT]) begin
      rsp_valid_d[tag_id_q[LAT]] = 1'b1;
      rsp_result_d               = fma_result;
    end else begin
      rsp_result_d               = rsp_result_q;
    end
  end

  // State registers with asynchronous reset; in-flight tags are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= IDW'(NREQ-1);
      fma_a_q      <= 32'd0;
      fma_b_q      <= 32'd0;
      fma_c_q      <= 32'd0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= 32'd0;
      issue_cnt_q  <= 16'd0;
    end else begin
      last_q       <= last_d;
      fma_a_q      <= fma_a_d;
      fma_b_q      <= fma_b_d;
      fma_c_q      <= fma_c_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign req_ready  = ready_s;
  assign fma_a      = fma_a_q;
  assign fma_b      = fma_b_q;
  assign fma_c      = fma_c_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign issue_cnt  = issue_cnt_q;
  assign busy       = (|tag_vld_q) | (|rsp_valid_q);

endmodule
